// File: rtl/rsa_mont_exp_if.sv
// rtl/rsa_mont_exp_if.sv - stream bundle between the exponent controller, its host and the Montgomery multiplier
//
// Signal groups (direction as seen by the controller, modport slave):
//   i_*  job request stream in   : i_valid/i_ready, i_msg, i_key, i_modulus, i_rmont
//   m_*  multiply request out    : m_valid/m_ready, m_a, m_b, m_modulus
//   s_*  multiply result in      : s_valid/s_ready, s_result
//   o_*  exponent result out     : o_valid/o_ready, o_result
// modport master is the environment side (host plus multiplier).
interface rsa_mont_exp_if #(
    parameter int MOD_WIDTH = 256,
    parameter int KEY_WIDTH = 256
);
    logic                 i_valid;
    logic                 i_ready;
    logic [MOD_WIDTH-1:0] i_msg;
    logic [KEY_WIDTH-1:0] i_key;
    logic [MOD_WIDTH-1:0] i_modulus;
    logic [MOD_WIDTH-1:0] i_rmont;

    logic                 m_valid;
    logic                 m_ready;
    logic [MOD_WIDTH-1:0] m_a;
    logic [MOD_WIDTH-1:0] m_b;
    logic [MOD_WIDTH-1:0] m_modulus;

    logic                 s_valid;
    logic                 s_ready;
    logic [MOD_WIDTH-1:0] s_result;

    logic                 o_valid;
    logic                 o_ready;
    logic [MOD_WIDTH-1:0] o_result;

    modport slave (
        input  i_valid, i_msg, i_key, i_modulus, i_rmont,
        output i_ready,
        output m_valid, m_a, m_b, m_modulus,
        input  m_ready,
        input  s_valid, s_result,
        output s_ready,
        output o_valid, o_result,
        input  o_ready
    );

    modport master (
        output i_valid, i_msg, i_key, i_modulus, i_rmont,
        input  i_ready,
        input  m_valid, m_a, m_b, m_modulus,
        output m_ready,
        output s_valid, s_result,
        input  s_ready,
        input  o_valid, o_result,
        output o_ready
    );
endinterface

// File: rtl/rsa_mont_exp.sv
// rtl/rsa_mont_exp.sv - LSB-first square-and-multiply controller driving a Montgomery multiplier
//
// Computes msg^key mod N with all operands kept in Montgomery form. The block
// does no arithmetic itself; it sequences one multiply at a time through the
// m_* request / s_* result streams of the bus interface.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - rsa_mont_exp_if.slave (job in i_*, multiply request m_*,
//          multiply result s_*, exponent result o_*)
//
// Build option RSA_MONT_EXP_DEMONT_EN: when defined, one final multiply by 1
// converts the result out of Montgomery form; otherwise o_result is left in
// Montgomery form (msg^key * R mod N).
module rsa_mont_exp #(
    parameter int MOD_WIDTH = 256,
    parameter int KEY_WIDTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    rsa_mont_exp_if.slave bus
);

    localparam int IDX_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        MUL_CHK     = 4'd1,
        MUL_REQ     = 4'd2,
        MUL_WAIT    = 4'd3,
        SQR_CHK     = 4'd4,
        SQR_REQ     = 4'd5,
        SQR_WAIT    = 4'd6,
        FINISH      = 4'd7,
        DEMONT_REQ  = 4'd8,
        DEMONT_WAIT = 4'd9,
        DONE        = 4'd10
    } state_e;

    state_e               state_q, state_d;
    logic [MOD_WIDTH-1:0] base_q, base_d;
    logic [MOD_WIDTH-1:0] acc_q, acc_d;
    logic [MOD_WIDTH-1:0] mod_q, mod_d;
    logic [MOD_WIDTH-1:0] res_q, res_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.i_valid) state_d = MUL_CHK;
            MUL_CHK:  state_d = key_q[idx_q] ? MUL_REQ : SQR_CHK;
            MUL_REQ:  if (bus.m_ready) state_d = MUL_WAIT;
            MUL_WAIT: if (bus.s_valid) state_d = SQR_CHK;
            // The square after the top key bit would never be used, so skip it.
            SQR_CHK:  state_d = (idx_q == LAST_IDX) ? FINISH : SQR_REQ;
            SQR_REQ:  if (bus.m_ready) state_d = SQR_WAIT;
            SQR_WAIT: if (bus.s_valid) state_d = MUL_CHK;
`ifdef RSA_MONT_EXP_DEMONT_EN
            FINISH:      state_d = DEMONT_REQ;
            DEMONT_REQ:  if (bus.m_ready) state_d = DEMONT_WAIT;
            DEMONT_WAIT: if (bus.s_valid) state_d = DONE;
`else
            FINISH:      state_d = DONE;
`endif
            DONE:     if (bus.o_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            acc_q  <= '0;
            mod_q  <= '0;
            res_q  <= '0;
            key_q  <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            acc_q  <= acc_d;
            mod_q  <= mod_d;
            res_q  <= res_d;
            key_q  <= key_d;
            idx_q  <= idx_d;
        end
    end

    // Datapath next-state: results are only taken while in a WAIT state, so a
    // stray s_valid anywhere else has no effect.
    always_comb begin
        base_d = base_q;
        acc_d  = acc_q;
        mod_d  = mod_q;
        res_d  = res_q;
        key_d  = key_q;
        idx_d  = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    base_d = bus.i_msg;
                    acc_d  = bus.i_rmont;
                    key_d  = bus.i_key;
                    mod_d  = bus.i_modulus;
                    idx_d  = '0;
                end
            end
            MUL_WAIT: begin
                if (bus.s_valid) acc_d = bus.s_result;
            end
            SQR_WAIT: begin
                if (bus.s_valid) begin
                    base_d = bus.s_result;
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
`ifdef RSA_MONT_EXP_DEMONT_EN
            DEMONT_WAIT: begin
                if (bus.s_valid) res_d = bus.s_result;
            end
`else
            FINISH: begin
                res_d = acc_q;
            end
`endif
            default: ;
        endcase
    end

    // Outputs decode from state_q only, so they fall asynchronously with rst
    // and the request payload cannot change while m_valid waits for m_ready.
    always_comb begin
        bus.i_ready   = (state_q == IDLE);
        bus.m_valid   = 1'b0;
        bus.s_ready   = 1'b0;
        bus.o_valid   = (state_q == DONE);
        bus.o_result  = res_q;
        bus.m_a       = '0;
        bus.m_b       = '0;
        bus.m_modulus = '0;
        case (state_q)
            MUL_REQ: begin
                bus.m_valid   = 1'b1;
                bus.m_a       = acc_q;
                bus.m_b       = base_q;
                bus.m_modulus = mod_q;
            end
            SQR_REQ: begin
                bus.m_valid   = 1'b1;
                bus.m_a       = base_q;
                bus.m_b       = base_q;
                bus.m_modulus = mod_q;
            end
`ifdef RSA_MONT_EXP_DEMONT_EN
            DEMONT_REQ: begin
                // acc * 1 * R^-1 strips the Montgomery factor.
                bus.m_valid   = 1'b1;
                bus.m_a       = acc_q;
                bus.m_b       = MOD_WIDTH'(1);
                bus.m_modulus = mod_q;
            end
            DEMONT_WAIT: bus.s_ready = 1'b1;
`endif
            MUL_WAIT: bus.s_ready = 1'b1;
            SQR_WAIT: bus.s_ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rsa_mont_exp.sv
// tb/tb_rsa_mont_exp.sv - self-checking bench for rsa_mont_exp with a 3-cycle Montgomery responder
module tb_rsa_mont_exp;

    localparam int MW = 8;
    localparam int KW = 8;

`ifdef RSA_MONT_EXP_DEMONT_EN
    localparam bit DEMONT = 1'b1;
`else
    localparam bit DEMONT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rsa_mont_exp_if #(.MOD_WIDTH(MW), .KEY_WIDTH(KW)) bus ();

    rsa_mont_exp #(.MOD_WIDTH(MW), .KEY_WIDTH(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] msg;
        logic [7:0] key;
        logic [7:0] modulus;
        logic [7:0] rmont;
        logic [7:0] exp_plain;
        logic [7:0] exp_mont;
        int         mhs;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         mhs;
        logic [7:0] fa;
        logic [7:0] fb;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Responder state and logs
    int         rs;
    int         lat;
    int         stall_req;
    bit         stall_seen;
    bit         stall_ok;
    logic [7:0] hold_a, hold_b;
    logic [7:0] cap_a, cap_b, cap_n;
    logic [7:0] rsp;
    int         job_mhs;
    logic [7:0] first_a, first_b;
    bit         overlap_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // a*b*R^-1 mod n found by search; n is small and odd
    function automatic logic [7:0] mont(input int a, input int b, input int n);
        int p;
        int res;
        res = 0;
        if (n != 0) begin
            p = (a * b) % n;
            for (int r = n - 1; r >= 0; r--)
                if (((r * 256) % n) == p) res = r;
        end
        return 8'(res);
    endfunction

    // Behavioural multiplier: accepts one request, answers 3 cycles later.
    initial begin
        bus.m_ready  = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_result = '0;
        rs = 0; lat = 0; stall_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rs = 0;
                bus.m_ready = 1'b0;
                bus.s_valid = 1'b0;
                stall_seen  = 1'b0;
            end else begin
                case (rs)
                    0: begin
                        if (bus.m_valid || stall_seen) begin
                            if (stall_req > 0) begin
                                if (!stall_seen) begin
                                    stall_seen = 1'b1;
                                    hold_a = bus.m_a;
                                    hold_b = bus.m_b;
                                end else if (!(bus.m_valid === 1'b1 && bus.m_a === hold_a && bus.m_b === hold_b)) begin
                                    stall_ok = 1'b0;
                                end
                                if (stall_req == 3) begin
                                    bus.s_valid  = 1'b1;
                                    bus.s_result = 8'hAA;
                                end else begin
                                    bus.s_valid = 1'b0;
                                end
                                stall_req--;
                            end else begin
                                bus.s_valid = 1'b0;
                                stall_seen  = 1'b0;
                                bus.m_ready = 1'b1;
                                cap_a = bus.m_a;
                                cap_b = bus.m_b;
                                cap_n = bus.m_modulus;
                                rs = 1;
                            end
                        end
                    end
                    1: begin
                        bus.m_ready = 1'b0;
                        if (job_mhs == 0) begin
                            first_a = cap_a;
                            first_b = cap_b;
                        end
                        job_mhs++;
                        rsp = mont(int'(cap_a), int'(cap_b), int'(cap_n));
                        lat = 2;
                        rs  = 2;
                    end
                    2: begin
                        lat--;
                        if (lat == 0) begin
                            bus.s_valid  = 1'b1;
                            bus.s_result = rsp;
                            rs = 3;
                        end
                    end
                    default: begin
                        bus.s_valid = 1'b0;
                        rs = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.m_valid === 1'b1 && bus.s_ready === 1'b1) overlap_seen = 1'b1;
        end
    end

    task automatic send_job(input vec_t v);
        sb_t e;
        bit  got;
        job_mhs       = 0;
        bus.i_valid   = 1'b1;
        bus.i_msg     = v.msg;
        bus.i_key     = v.key;
        bus.i_modulus = v.modulus;
        bus.i_rmont   = v.rmont;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            if (bus.i_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check("i_handshake", 32'(got), 1);
        if (got) begin
            e.res = DEMONT ? v.exp_plain : v.exp_mont;
            e.mhs = v.mhs + (DEMONT ? 1 : 0);
            e.fa  = v.key[0] ? v.rmont : v.msg;
            e.fb  = v.msg;
            sb.push_back(e);
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic get_result(input int hold);
        sb_t        e;
        bit         seen;
        bit         stable;
        logic [7:0] r0;
        seen = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen = 1'b1;
        end
        check("o_valid_seen", 32'(seen), 1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!seen) return;
        r0 = bus.o_result;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!(bus.o_valid === 1'b1 && bus.o_result === r0 && bus.i_ready === 1'b0)) stable = 1'b0;
        end
        if (hold > 0) check("o_hold_stable", 32'(stable), 1);
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.o_ready = 1'b0;
        check("i_ready_after_o", 32'(bus.i_ready), 1);
        check("o_valid_dropped", 32'(bus.o_valid), 0);
        check("o_result", 32'(r0), 32'(e.res));
        check("m_handshakes", 32'(job_mhs), 32'(e.mhs));
        check("first_req_a", 32'(first_a), 32'(e.fa));
        check("first_req_b", 32'(first_b), 32'(e.fb));
    endtask

    initial begin
        sb_t e;
        bit  got;

        //        msg     key     N       rmont   plain   mont    mhs w/o demont
        vecs[0] = '{8'd136, 8'd7,   8'd143, 8'd113, 8'd47,  8'd20,  10};
        vecs[1] = '{8'd136, 8'd0,   8'd143, 8'd113, 8'd1,   8'd113, 7};
        vecs[2] = '{8'd136, 8'd1,   8'd143, 8'd113, 8'd5,   8'd136, 8};
        vecs[3] = '{8'd136, 8'd255, 8'd143, 8'd113, 8'd34,  8'd124, 15};
        vecs[4] = '{8'd136, 8'd128, 8'd143, 8'd113, 8'd92,  8'd100, 8};
        vecs[5] = '{8'd105, 8'd165, 8'd221, 8'd35,  8'd209, 8'd22,  11};

        rst           = 1'b0;
        stall_req     = 0;
        stall_ok      = 1'b1;
        job_mhs       = 0;
        bus.i_valid   = 1'b0;
        bus.i_msg     = '0;
        bus.i_key     = '0;
        bus.i_modulus = '0;
        bus.i_rmont   = '0;
        bus.o_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_i_ready",   32'(bus.i_ready), 1);
        check("rst_m_valid",   32'(bus.m_valid), 0);
        check("rst_s_ready",   32'(bus.s_ready), 0);
        check("rst_o_valid",   32'(bus.o_valid), 0);
        check("rst_o_result",  32'(bus.o_result), 0);
        check("rst_m_a",       32'(bus.m_a), 0);
        check("rst_m_modulus", 32'(bus.m_modulus), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_job(vecs[i]);
            get_result(0);
        end

        // First multiply request stalled for 5 cycles with a stray s_valid pulse
        stall_ok  = 1'b1;
        stall_req = 5;
        send_job(vecs[0]);
        get_result(0);
        check("stall_applied", 32'(stall_req), 0);
        check("stall_payload_stable", 32'(stall_ok), 1);

        // Result held under back-pressure, then a back-to-back job
        send_job(vecs[0]);
        get_result(10);
        send_job(vecs[2]);
        get_result(0);

        // Reset while the 4th multiply is outstanding
        send_job(vecs[3]);
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            #1;
            if (job_mhs >= 4) got = 1'b1;
        end
        check("reach_4th_wait", 32'(got), 1);
        check("s_ready_before_rst", 32'(bus.s_ready), 1);
        rst = 1'b0;
        #1;
        check("midrst_m_valid", 32'(bus.m_valid), 0);
        check("midrst_s_ready", 32'(bus.s_ready), 0);
        check("midrst_i_ready", 32'(bus.i_ready), 1);
        check("midrst_o_valid", 32'(bus.o_valid), 0);
        if (sb.size() > 0) e = sb.pop_front();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_job(vecs[5]);
        get_result(0);

        check("m_valid_s_ready_overlap", 32'(overlap_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
